weight_updater_seq: RTL and testbench

// Multi-weight, sequential successor of the single-weight combinational back-prop update.

---
 rtl/weight_update_pkg.sv | 29 ++
 rtl/weight_updater_seq_if.sv | 26 ++
 rtl/seq_divider_signed.sv | 77 +++++++
 rtl/weight_updater_seq.sv | 145 ++++++++++++++
 tb/tb_weight_updater_seq.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_update_pkg.sv
// Shared state encoding and width-generic saturation helpers for the sequential weight updater.
// Helpers work on a wide signed container so one definition serves every WIDTH up to 64.
package weight_update_pkg;

    localparam int MAX_W = 130;

    typedef logic signed [MAX_W-1:0] wide_t;
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_MUL   = 2'd1;
    localparam state_t ST_DIV   = 2'd2;
    localparam state_t ST_WRITE = 2'd3;

    function automatic wide_t sat_trunc(input wide_t x, input int w);
        wide_t hi;
        wide_t lo;
        hi = wide_t'((MAX_W'(1) << (w - 1)) - MAX_W'(1));
        lo = -hi - wide_t'(1);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
        return sat_trunc(a + b, w);
    endfunction

endpackage

// File: rtl/weight_updater_seq_if.sv
// Update-request handshake and completion report of the weight updater.
interface weight_updater_seq_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 3
);
    logic                    req_valid;
    logic                    req_ready;
    logic [IDX_W-1:0]        req_idx;
    logic signed [WIDTH-1:0] req_bp;
    logic signed [WIDTH-1:0] req_tm;
    logic signed [WIDTH-1:0] req_td;
    logic                    done_valid;
    logic [IDX_W-1:0]        done_idx;
    logic signed [WIDTH-1:0] done_w;
    logic                    done_err;

    modport master (
        output req_valid, req_idx, req_bp, req_tm, req_td,
        input  req_ready, done_valid, done_idx, done_w, done_err
    );

    modport slave (
        input  req_valid, req_idx, req_bp, req_tm, req_td,
        output req_ready, done_valid, done_idx, done_w, done_err
    );
endinterface

// File: rtl/seq_divider_signed.sv
// Restoring signed divider, one quotient bit per cycle, truncating toward zero.
// done is high during the final iteration; quo holds the result from the next cycle until the next start.
module seq_divider_signed #(
    parameter int NUM_W = 64,
    parameter int DEN_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [NUM_W-1:0] num,
    input  logic signed [DEN_W-1:0] den,
    output logic                    busy,
    output logic                    done,
    output logic signed [NUM_W-1:0] quo
);
    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] acc_q, acc_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             neg_q, neg_d;
    logic [DEN_W:0]   trial;

    always_comb begin
        acc_d  = acc_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        neg_d  = neg_q;
        trial  = {rem_q, acc_q[NUM_W-1]};
        if (start) begin
            acc_d  = num[NUM_W-1] ? -num : num;
            dsr_d  = den[DEN_W-1] ? -den : den;
            rem_d  = '0;
            cnt_d  = CNT_W'(NUM_W - 1);
            busy_d = 1'b1;
            neg_d  = num[NUM_W-1] ^ den[DEN_W-1];
        end else if (busy_q) begin
            // acc shifts the dividend out at the top and the quotient in at the bottom
            if (trial >= {1'b0, dsr_q}) begin
                rem_d = DEN_W'(trial - {1'b0, dsr_q});
                acc_d = {acc_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DEN_W-1:0];
                acc_d = {acc_q[NUM_W-2:0], 1'b0};
            end
            if (cnt_q == '0) busy_d = 1'b0;
            else             cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            neg_q  <= neg_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);
    assign quo  = neg_q ? $signed(-acc_q) : $signed(acc_q);

endmodule

// File: rtl/weight_updater_seq.sv
// Multi-weight sequential back-prop update: w <= w + bp*gate(w)*tm/td with a multi-cycle divider.
// Weights live in a register file with a direct load port and a combinational read port.
module weight_updater_seq
    import weight_update_pkg::*;
#(
    parameter int                WIDTH     = 32,
    parameter int                N_WEIGHTS = 8,
    parameter int                GATE_MODE = 1,
    parameter int                SATURATE  = 1,
    parameter logic signed [WIDTH-1:0] INIT_W = '0,
    localparam int               IDX_W     = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    weight_updater_seq_if.slave     bus,
    input  logic                    ld_en,
    input  logic [IDX_W-1:0]        ld_idx,
    input  logic signed [WIDTH-1:0] ld_w,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic signed [WIDTH-1:0] rd_w
);
    localparam logic signed [WIDTH-1:0] ZERO = '0;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [WIDTH-1:0] bp_q, bp_d;
    logic signed [WIDTH-1:0] tm_q, tm_d;
    logic signed [WIDTH-1:0] td_q, td_d;
    logic signed [WIDTH-1:0] w_q, w_d;
    logic                    gate_q, gate_d;
    logic signed [WIDTH-1:0] wgt_q [N_WEIGHTS];
    logic signed [WIDTH-1:0] wgt_d [N_WEIGHTS];

    logic signed [WIDTH-1:0]   neg2w;
    logic                      gate_now;
    logic                      td_zero;
    logic signed [2*WIDTH-1:0] prod;
    logic                      div_start, div_busy, div_done;
    logic signed [2*WIDTH-1:0] div_quo;
    logic signed [WIDTH-1:0]   q_red, ws, wn;

    // Legacy gate: open when -2*w, taken modulo 2^WIDTH, is non-negative
    assign neg2w    = -(w_q <<< 1);
    assign gate_now = (GATE_MODE != 0) ? (neg2w >= ZERO) : 1'b1;
    assign td_zero  = (td_q == ZERO);
    assign prod     = {{WIDTH{bp_q[WIDTH-1]}}, bp_q} * {{WIDTH{tm_q[WIDTH-1]}}, tm_q};

    seq_divider_signed #(.NUM_W(2 * WIDTH), .DEN_W(WIDTH)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (prod),
        .den   (td_q),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo)
    );

    always_comb begin
        if (SATURATE != 0) begin
            q_red = WIDTH'(sat_trunc(wide_t'(div_quo), WIDTH));
        end else begin
            q_red = WIDTH'(div_quo);
        end
        ws = (gate_q && !td_zero) ? q_red : ZERO;
        if (SATURATE != 0) begin
            wn = WIDTH'(sat_add(wide_t'(w_q), wide_t'(ws), WIDTH));
        end else begin
            wn = w_q + ws;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bp_d      = bp_q;
        tm_d      = tm_q;
        td_d      = td_q;
        w_d       = w_q;
        gate_d    = gate_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_MUL;
                    idx_d   = bus.req_idx;
                    bp_d    = bus.req_bp;
                    tm_d    = bus.req_tm;
                    td_d    = bus.req_td;
                    w_d     = wgt_q[bus.req_idx];
                end
            end
            ST_MUL: begin
                gate_d = gate_now;
                if (gate_now && !td_zero) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DIV: begin
                if (div_done || !div_busy) state_d = ST_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A same-edge load to the updated index overrides the update result
    always_comb begin
        for (int i = 0; i < N_WEIGHTS; i++) wgt_d[i] = wgt_q[i];
        if (state_q == ST_WRITE && !td_zero) wgt_d[idx_q] = wn;
        if (ld_en) wgt_d[ld_idx] = ld_w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bp_q    <= '0;
            tm_q    <= '0;
            td_q    <= '0;
            w_q     <= '0;
            gate_q  <= 1'b0;
            for (int i = 0; i < N_WEIGHTS; i++) wgt_q[i] <= INIT_W;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bp_q    <= bp_d;
            tm_q    <= tm_d;
            td_q    <= td_d;
            w_q     <= w_d;
            gate_q  <= gate_d;
            for (int i = 0; i < N_WEIGHTS; i++) wgt_q[i] <= wgt_d[i];
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.done_valid = (state_q == ST_WRITE);
    assign bus.done_idx   = (state_q == ST_WRITE) ? idx_q : '0;
    assign bus.done_w     = (state_q == ST_WRITE) ? (td_zero ? w_q : wn) : ZERO;
    assign bus.done_err   = (state_q == ST_WRITE) && td_zero;
    assign rd_w           = wgt_q[rd_idx];

endmodule

// File: tb/tb_weight_updater_seq.sv
// Scoreboard bench for weight_updater_seq: directed cases plus randomized updates against an arithmetic model.
module tb_weight_updater_seq;
    localparam int WIDTH = 32;
    localparam int NW    = 8;
    localparam int IDX_W = 3;
    localparam longint HI32 = 64'sd2147483647;
    localparam longint LO32 = -64'sd2147483648;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    ld_en = 1'b0;
    logic [IDX_W-1:0]        ld_idx = '0;
    logic signed [WIDTH-1:0] ld_w = '0;
    logic [IDX_W-1:0]        rd_idx = '0;
    logic signed [WIDTH-1:0] rd_w;

    weight_updater_seq_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    weight_updater_seq #(
        .WIDTH(WIDTH), .N_WEIGHTS(NW), .GATE_MODE(1), .SATURATE(1), .INIT_W(32'sd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_w(ld_w),
        .rd_idx(rd_idx), .rd_w(rd_w)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        longint      w;
        bit          err;
        int          lat;
        int unsigned t;
    } exp_t;

    exp_t   exp_q[$];
    longint ref_w [NW];
    int     total = 0;
    int     bad = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic longint clamp32(input longint x);
        if (x > HI32) return HI32;
        if (x < LO32) return LO32;
        return x;
    endfunction

    // Reference: ws = bp*gate(w)*tm/td, truncating division, saturated to 32 bits
    function automatic exp_t model(input int idx, input int bp, input int tm, input int td);
        exp_t   e;
        longint w, m2, p, q, ws;
        bit     gate;
        w    = ref_w[idx];
        e.idx = idx;
        e.err = (td == 0);
        m2   = (-2 * w) & 64'h0000_0000_FFFF_FFFF;
        gate = (m2 < 64'sd2147483648);
        if (td == 0) begin
            e.w   = w;
            e.lat = 2;
        end else begin
            if (gate) begin
                p  = longint'(bp) * longint'(tm);
                q  = p / longint'(td);
                ws = clamp32(q);
                e.lat = 66;
            end else begin
                ws = 0;
                e.lat = 2;
            end
            e.w = clamp32(w + ws);
            ref_w[idx] = e.w;
        end
        e.t = 0;
        return e;
    endfunction

    task automatic issue(input int idx, input int bp, input int tm, input int td);
        exp_t e;
        int   n;
        bus.req_idx   = IDX_W'(idx);
        bus.req_bp    = bp;
        bus.req_tm    = tm;
        bus.req_td    = td;
        bus.req_valid = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            timeout("accept");
            bus.req_valid = 1'b0;
            return;
        end
        e   = model(idx, bp, tm, td);
        e.t = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic raw_load(input int idx, input int val);
        ld_en  = 1'b1;
        ld_idx = IDX_W'(idx);
        ld_w   = val;
        @(negedge clk);
        ld_en  = 1'b0;
    endtask

    task automatic load(input int idx, input int val);
        ref_w[idx] = val;
        raw_load(idx, val);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout("drain");
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports completion
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (exp_q.size() != 0 && cyc > exp_q[0].t)
                chk("ready_low_busy", bus.req_ready, 0);
            if (bus.done_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: idx=%0d w=%0d (t=%0t)", bus.done_idx, bus.done_w, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_idx", bus.done_idx, e.idx);
                    chk("done_w", bus.done_w, e.w);
                    chk("done_err", bus.done_err, e.err);
                    chk("latency", cyc - e.t, e.lat);
                end
            end
        end
    end

    initial begin
        int n;
        int idx, bp, tm, td, r;
        bus.req_valid = 1'b0;
        bus.req_idx   = '0;
        bus.req_bp    = '0;
        bus.req_tm    = '0;
        bus.req_td    = '0;
        for (int i = 0; i < NW; i++) ref_w[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_done_valid", bus.done_valid, 0);
        chk("rst_done_w", bus.done_w, 0);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) begin
            rd_idx = IDX_W'(i);
            #1 chk("rst_rd_w", rd_w, 0);
        end
        @(negedge clk);

        load(2, -4);
        load(0, 3);
        load(1, -5);
        load(3, 0);
        load(4, 0);
        load(5, -100);
        load(6, -20);
        load(7, -8);

        issue(2, 10, 1, 2);
        issue(0, 100, 1, 1);
        issue(1, 7, 3, 0);
        issue(3, -7, 1, 2);
        issue(4, 7, -1, -2);
        issue(5, 32'h8000_0000, 4, 1);
        wait_idle();
        rd_idx = 3'd1;
        #1 chk("div0_unchanged", rd_w, -5);
        rd_idx = 3'd2;
        #1 chk("basic_written", rd_w, 1);

        // load to the in-flight index during DIV must not disturb the snapshot
        issue(6, 50, 3, 7);
        repeat (5) @(negedge clk);
        raw_load(6, 999);
        wait_idle();
        rd_idx = 3'd6;
        #1 chk("mid_load_overwritten", rd_w, ref_w[6]);

        // load in the WRITE cycle wins over the update
        issue(7, -30, 2, 3);
        n = 0;
        while (bus.done_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.done_valid !== 1'b1) timeout("write_cycle");
        load(7, 1234);
        rd_idx = 3'd7;
        #1 chk("load_wins", rd_w, 1234);
        wait_idle();

        // reset while dividing drops the update
        issue(3, 1000, 1, 3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) ref_w[i] = 0;
        chk("rst_mid_done_valid", bus.done_valid, 0);
        chk("rst_mid_ready", bus.req_ready, 1);
        for (int i = 0; i < NW; i++) begin
            rd_idx = IDX_W'(i);
            #1 chk("rst_mid_rd_w", rd_w, 0);
        end
        repeat (80) @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                if ($urandom_range(0, 4) == 0) load($urandom_range(0, NW - 1), int'($urandom));
                else load($urandom_range(0, NW - 1), int'($urandom_range(0, 200)) - 100);
            end
            idx = $urandom_range(0, NW - 1);
            if ($urandom_range(0, 3) == 0) bp = int'($urandom);
            else bp = int'($urandom_range(0, 2000)) - 1000;
            if ($urandom_range(0, 3) == 0) tm = int'($urandom);
            else tm = int'($urandom_range(0, 100)) - 50;
            r = $urandom_range(0, 7);
            if (r == 0) td = 0;
            else if (r == 1) td = int'($urandom);
            else td = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : -int'($urandom_range(1, 20));
            issue(idx, bp, tm, td);
        end
        wait_idle();

        for (int i = 0; i < NW; i++) begin
            rd_idx = IDX_W'(i);
            #1 chk("final_rd_w", rd_w, ref_w[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
